grf_dump_reader: RTL and testbench

Sequential read-out engine for the general register file: on a start pulse it walks a contiguous range of GRF addresses through one combinational read port and streams each `{index, value}` pair over a valid/ready interface to a downstream consumer (UART/debug bridge). It sits between the CPU's GRF read port (muxed in while frozen) and the board debug output. While a dump is in progress it asserts `freeze` so the pipeline stops issuing GRF writes.

---
 rtl/grf_dump_reader.sv | 136 +++++++++++++
 tb/tb_grf_dump_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_dump_reader.sv
// Purpose : walk GRF[FIRST_REG..LAST_REG] through one read port and stream {idx, data} words.
// Latency : first word valid 1 cycle after start is sampled; N words + 2 cycles start-to-done.
// Backpress: dump_valid/dump_ready; an unaccepted word and the read pointer hold until accepted.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   start, abort      begin a dump (IDLE only) / cancel a dump (any non-IDLE state)
//   rd_addr, rd_data  GRF read port; rd_data is a combinational response to rd_addr
//   freeze            high in FILL and STREAM; the CPU must not commit GRF writes
//   busy, done        busy while not IDLE; done is a one-cycle pulse after the final handshake
//   dump_*            output word stream: valid/ready, GRF index, GRF value, last-word flag
module grf_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        freeze,
    output logic        busy,
    output logic        done,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        dump_last
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  ptr;
    logic [4:0]  ptr_nxt;
    logic        valid_nxt;
    logic        last_nxt;
    logic [4:0]  idx_nxt;
    logic [31:0] data_nxt;
    logic        load;
    logic        handshake;

    assign handshake = dump_valid && dump_ready;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        valid_nxt = dump_valid;
        last_nxt  = dump_last;
        idx_nxt   = dump_idx;
        data_nxt  = dump_data;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    ptr_nxt   = FIRST_IDX;
                end
            end
            FILL: begin
                load      = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (handshake) begin
                    if (dump_last) begin
                        valid_nxt = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        // Reload in the handshake edge so back-to-back words need no bubble.
                        load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort beats a simultaneous handshake; the held word is dropped, no done pulse.
        if (abort && (state != IDLE)) begin
            load      = 1'b0;
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end

        // rd_data is sampled only here, so a same-cycle forwarded GRF write is captured.
        if (load) begin
            data_nxt  = rd_data;
            idx_nxt   = ptr;
            last_nxt  = (ptr == LAST_IDX);
            valid_nxt = 1'b1;
            // 5-bit wrap past index 31 is harmless: no load follows the last word.
            ptr_nxt   = ptr + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 5'd0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_idx   <= 5'd0;
            dump_data  <= 32'd0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            dump_valid <= valid_nxt;
            dump_last  <= last_nxt;
            dump_idx   <= idx_nxt;
            dump_data  <= data_nxt;
        end
    end

    assign rd_addr = ptr;
    assign freeze  = (state == FILL) || (state == STREAM);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_grf_dump_reader.sv
// Bench for grf_dump_reader: three instances (full range, single word 5..5, range 3..6)
// sharing clock, reset, abort, ready and a behavioural GRF with same-cycle write forwarding.
// Inputs are driven and outputs observed on the falling edge.
module tb_grf_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        abort;
    logic        dump_ready;
    logic        start_a, start_b, start_c;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] grf [32];

    logic [4:0]  a_rd_addr, b_rd_addr, c_rd_addr;
    logic [31:0] a_rd_data, b_rd_data, c_rd_data;
    logic        a_freeze, a_busy, a_done, a_valid, a_last;
    logic        b_freeze, b_busy, b_done, b_valid, b_last;
    logic        c_freeze, c_busy, c_done, c_valid, c_last;
    logic [4:0]  a_idx, b_idx, c_idx;
    logic [31:0] a_data, b_data, c_data;

    int tests_run = 0;
    int fails     = 0;

    assign a_rd_data = (wr_en && wr_addr == a_rd_addr) ? wr_data : grf[a_rd_addr];
    assign b_rd_data = (wr_en && wr_addr == b_rd_addr) ? wr_data : grf[b_rd_addr];
    assign c_rd_data = (wr_en && wr_addr == c_rd_addr) ? wr_data : grf[c_rd_addr];

    grf_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .freeze(a_freeze), .busy(a_busy),
        .done(a_done), .dump_valid(a_valid), .dump_ready(dump_ready), .dump_idx(a_idx),
        .dump_data(a_data), .dump_last(a_last)
    );

    grf_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .freeze(b_freeze), .busy(b_busy),
        .done(b_done), .dump_valid(b_valid), .dump_ready(dump_ready), .dump_idx(b_idx),
        .dump_data(b_data), .dump_last(b_last)
    );

    grf_dump_reader #(.FIRST_REG(3), .LAST_REG(6)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .freeze(c_freeze), .busy(c_busy),
        .done(c_done), .dump_valid(c_valid), .dump_ready(dump_ready), .dump_idx(c_idx),
        .dump_data(c_data), .dump_last(c_last)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({a_valid, a_last, a_freeze, a_busy, a_done, a_idx, a_rd_addr} !== 15'd0 || a_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_a: ctl=%b idx=%0d addr=%0d data=%h, required all zero",
                     {a_valid, a_last, a_freeze, a_busy, a_done}, a_idx, a_rd_addr, a_data);
        end
        tests_run++;
        if ({b_valid, b_busy, b_done, c_valid, c_busy, c_done, b_freeze, c_freeze} !== 8'd0) begin
            fails++;
            $display("FAIL reset_bc: got %b, required 0",
                     {b_valid, b_busy, b_done, c_valid, c_busy, c_done, b_freeze, c_freeze});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_valid, a_busy, a_freeze, a_done} !== 4'd0 || a_rd_addr !== 5'd0) begin
            fails++;
            $display("FAIL reset_release_idle: ctl=%b addr=%0d, required 0/0",
                     {a_valid, a_busy, a_freeze, a_done}, a_rd_addr);
        end
    endtask

    task automatic test_full_dump();
        int edges;
        int nwords;
        int done_edge;
        logic [31:0] exp_data;
        for (int i = 0; i < 32; i++) grf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
        dump_ready = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        edges = 1; nwords = 0; done_edge = -1;
        tests_run++;
        if (a_freeze !== 1'b1 || a_busy !== 1'b1) begin
            fails++;
            $display("FAIL full_freeze_rise: freeze=%b busy=%b, required 1/1", a_freeze, a_busy);
        end
        while (edges < 100 && done_edge < 0) begin
            if (a_valid === 1'b1) begin
                exp_data = (nwords == 0) ? 32'd0 : 32'h1000_0000 + 32'(nwords);
                tests_run++;
                if (a_idx !== 5'(nwords) || a_data !== exp_data || a_last !== (nwords == 31) ||
                    edges != nwords + 2 || a_freeze !== 1'b1) begin
                    fails++;
                    $display("FAIL full_word: idx=%0d data=%h last=%b edge=%0d freeze=%b, required idx=%0d data=%h last=%b edge=%0d freeze=1",
                             a_idx, a_data, a_last, edges, a_freeze, nwords, exp_data, (nwords == 31), nwords + 2);
                end
                nwords++;
            end
            if (a_done === 1'b1) done_edge = edges;
            else begin
                @(negedge clk);
                edges++;
            end
        end
        tests_run++;
        if (nwords != 32 || done_edge != 34) begin
            fails++;
            $display("FAIL full_count_latency: words=%0d done_edge=%0d, required 32/34", nwords, done_edge);
        end
        tests_run++;
        if (a_freeze !== 1'b0 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_done_state: freeze=%b busy=%b valid=%b, required 0/1/0", a_freeze, a_busy, a_valid);
        end
        @(negedge clk);
        tests_run++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL full_done_pulse: done=%b busy=%b, required 0/0", a_done, a_busy);
        end
    endtask

    task automatic test_backpressure(input bit random_mode);
        logic [36:0] exp_q[$];
        logic [36:0] exp_w;
        logic        ready;
        logic        held;
        logic [4:0]  h_idx;
        logic [31:0] h_data;
        logic        h_last;
        int edges, stalls, cyc, accepted, done_edge;
        for (int i = 0; i < 32; i++) begin
            grf[i] = $urandom;
            exp_q.push_back({5'(i), grf[i]});
        end
        held = 1'b0; h_idx = '0; h_data = '0; h_last = 1'b0;
        stalls = 0; cyc = 0; accepted = 0; done_edge = -1;
        dump_ready = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        edges = 1;
        while (edges < 400 && done_edge < 0) begin
            if (held) begin
                tests_run++;
                if (a_valid !== 1'b1 || a_idx !== h_idx || a_data !== h_data || a_last !== h_last) begin
                    fails++;
                    $display("FAIL bp_hold: valid=%b idx=%0d data=%h last=%b, required 1/%0d/%h/%b",
                             a_valid, a_idx, a_data, a_last, h_idx, h_data, h_last);
                end
            end
            if (a_done === 1'b1) begin
                done_edge = edges;
            end else begin
                ready = random_mode ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
                cyc++;
                dump_ready = ready;
                held = 1'b0;
                if (a_valid === 1'b1) begin
                    if (ready) begin
                        accepted++;
                        tests_run++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL bp_extra_word: idx=%0d data=%h, required no further word", a_idx, a_data);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if ({a_idx, a_data} !== exp_w || a_last !== (exp_w[36:32] == 5'd31)) begin
                                fails++;
                                $display("FAIL bp_word: idx=%0d data=%h last=%b, required idx=%0d data=%h",
                                         a_idx, a_data, a_last, exp_w[36:32], exp_w[31:0]);
                            end
                        end
                    end else begin
                        held = 1'b1; h_idx = a_idx; h_data = a_data; h_last = a_last;
                        stalls++;
                    end
                end
                @(negedge clk);
                edges++;
            end
        end
        tests_run++;
        if (accepted != 32 || exp_q.size() != 0 || done_edge != 34 + stalls) begin
            fails++;
            $display("FAIL bp_summary: accepted=%0d left=%0d done_edge=%0d, required 32/0/%0d",
                     accepted, exp_q.size(), done_edge, 34 + stalls);
        end
        @(negedge clk);
        tests_run++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_done_pulse: done=%b busy=%b, required 0/0", a_done, a_busy);
        end
        dump_ready = 1'b1;
    endtask

    task automatic test_single_word();
        grf[5] = 32'hDEAD_BEEF;
        dump_ready = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b_valid !== 1'b1 || b_idx !== 5'd5 || b_data !== 32'hDEAD_BEEF || b_last !== 1'b1) begin
            fails++;
            $display("FAIL single_word: valid=%b idx=%0d data=%h last=%b, required 1/5/deadbeef/1",
                     b_valid, b_idx, b_data, b_last);
        end
        @(negedge clk);
        tests_run++;
        if (b_done !== 1'b1 || b_valid !== 1'b0 || b_freeze !== 1'b0) begin
            fails++;
            $display("FAIL single_done: done=%b valid=%b freeze=%b, required 1/0/0", b_done, b_valid, b_freeze);
        end
        @(negedge clk);
        tests_run++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: done=%b busy=%b, required 0/0", b_done, b_busy);
        end
    endtask

    task automatic test_abort();
        int n;
        logic saw_done;
        dump_ready = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 0;
        while (!(a_valid === 1'b1 && a_idx === 5'd7) && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            fails++;
            $display("FAIL abort_reach_idx7: idx=%0d valid=%b, required idx 7 valid", a_idx, a_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (a_valid !== 1'b0 || a_last !== 1'b0 || a_freeze !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_effect: valid=%b last=%b freeze=%b busy=%b done=%b, required all 0",
                     a_valid, a_last, a_freeze, a_busy, a_done);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_done === 1'b1 || a_valid === 1'b1) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: saw done/valid=%b, required 0", saw_done);
        end
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_valid !== 1'b1 || a_idx !== 5'd0 || a_data !== grf[0]) begin
            fails++;
            $display("FAIL abort_restart: valid=%b idx=%0d data=%h, required 1/0/%h", a_valid, a_idx, a_data, grf[0]);
        end
        n = 0;
        while (a_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 60) begin
            fails++;
            $display("FAIL abort_restart_done: done=%b, required 1 within 60 cycles", a_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_dump();
        dump_ready = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_valid !== 1'b1 || a_idx !== 5'd0 || a_rd_addr !== 5'd1) begin
            fails++;
            $display("FAIL midreset_held: valid=%b idx=%0d addr=%0d, required 1/0/1", a_valid, a_idx, a_rd_addr);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        tests_run++;
        if (a_rd_addr !== 5'd1 || a_idx !== 5'd0 || a_valid !== 1'b1 || a_busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_start_ignored: addr=%0d idx=%0d valid=%b busy=%b, required 1/0/1/1",
                     a_rd_addr, a_idx, a_valid, a_busy);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({a_valid, a_last, a_freeze, a_busy, a_done, a_idx, a_rd_addr} !== 15'd0 || a_data !== 32'd0) begin
            fails++;
            $display("FAIL midreset_async: ctl=%b idx=%0d addr=%0d data=%h, required all zero",
                     {a_valid, a_last, a_freeze, a_busy, a_done}, a_idx, a_rd_addr, a_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_after: busy=%b valid=%b done=%b, required 0/0/0", a_busy, a_valid, a_done);
        end
    endtask

    task automatic test_forwarding();
        grf[3] = 32'hAAAA_5555;
        for (int i = 4; i <= 6; i++) grf[i] = $urandom;
        dump_ready = 1'b1;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234_5678;
        tests_run++;
        if (c_freeze !== 1'b1) begin
            fails++;
            $display("FAIL fwd_freeze: freeze=%b, required 1", c_freeze);
        end
        @(negedge clk);
        grf[3] = wr_data;
        wr_en = 1'b0;
        tests_run++;
        if (c_valid !== 1'b1 || c_idx !== 5'd3 || c_data !== 32'h1234_5678 || c_last !== 1'b0) begin
            fails++;
            $display("FAIL fwd_first_word: valid=%b idx=%0d data=%h last=%b, required 1/3/12345678/0",
                     c_valid, c_idx, c_data, c_last);
        end
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (c_valid !== 1'b1 || c_idx !== 5'(k) || c_data !== grf[k] || c_last !== (k == 6)) begin
                fails++;
                $display("FAIL fwd_word: valid=%b idx=%0d data=%h last=%b, required 1/%0d/%h/%b",
                         c_valid, c_idx, c_data, c_last, k, grf[k], (k == 6));
            end
        end
        @(negedge clk);
        tests_run++;
        if (c_done !== 1'b1 || c_valid !== 1'b0) begin
            fails++;
            $display("FAIL fwd_done: done=%b valid=%b, required 1/0", c_done, c_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; abort = 1'b0; dump_ready = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        for (int i = 0; i < 32; i++) grf[i] = 32'd0;
        test_reset();
        test_full_dump();
        test_backpressure(1'b0);
        test_backpressure(1'b1);
        test_single_word();
        test_abort();
        test_reset_mid_dump();
        test_forwarding();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
